// File: rtl/saper_pkg.sv
// Shared definitions for the board scan / redraw blocks: level codes,
// board sizes and the scan FSM state type.
package saper_pkg;

  localparam logic [1:0] LVL_EASY   = 2'd1;
  localparam logic [1:0] LVL_MEDIUM = 2'd2;
  localparam logic [1:0] LVL_HARD   = 2'd3;

  localparam logic [4:0] SIZE_EASY   = 5'd8;
  localparam logic [4:0] SIZE_MEDIUM = 5'd10;
  localparam logic [4:0] SIZE_HARD   = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } scan_state_e;

  // Board edge length for a level code; unknown codes fall back to easy.
  function automatic logic [4:0] level_to_size(input logic [1:0] lvl);
    logic [4:0] sz;
    case (lvl)
      LVL_HARD:   sz = SIZE_HARD;
      LVL_MEDIUM: sz = SIZE_MEDIUM;
      LVL_EASY:   sz = SIZE_EASY;
      default:    sz = SIZE_EASY;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/board_index_counter.sv
// Row-major x/y walker over a size x size board, x fastest.
// nx/ny expose the position the next inc would move to, so callers can
// prefetch data for it on the same edge.
module board_index_counter #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] size,
  output logic [IDX_W-1:0] x,
  output logic [IDX_W-1:0] y,
  output logic [IDX_W-1:0] nx,
  output logic [IDX_W-1:0] ny,
  output logic             last
);

  logic [IDX_W-1:0] x_q, x_d, y_q, y_d;
  logic             x_end, y_end;

  // Wrap logic: x rolls into y, y rolls back to 0 after the final row.
  always_comb begin
    x_end = (x_q == size - IDX_W'(1));
    y_end = (y_q == size - IDX_W'(1));
    nx    = x_end ? '0 : x_q + IDX_W'(1);
    ny    = x_end ? (y_end ? '0 : y_q + IDX_W'(1)) : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      x_d = nx;
      y_d = ny;
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/defuse_scan.sv
// Defuse-flag read scanner: walks the active board row-major and streams
// (x, y, defused) records over valid/ready while counting flagged cells.
// Optional macro DEFUSE_SCAN_SKIP_EN: only flagged cells are emitted; an
// internal pointer walks one cell per cycle while the output slot is free.
module defuse_scan
  import saper_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int CNT_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         level,
  input  logic [7:0][7:0]    defuse_arr_easy,
  input  logic [9:0][9:0]    defuse_arr_medium,
  input  logic [15:0][15:0]  defuse_arr_hard,
  input  logic               out_ready,
  output logic               cell_valid,
  output logic [IDX_W-1:0]   cell_x,
  output logic [IDX_W-1:0]   cell_y,
  output logic               cell_defused,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   flag_count
);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] size_q, size_d;
  logic [IDX_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic             valid_q, valid_d;
  logic             def_q, def_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             clr, inc, last;
  logic [IDX_W-1:0] px, py, pnx, pny;

  board_index_counter #(.IDX_W(IDX_W)) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (inc),
    .size (size_q),
    .x    (px),
    .y    (py),
    .nx   (pnx),
    .ny   (pny),
    .last (last)
  );

  // Live read of the flag array for the given board size; no snapshot.
  function automatic logic rd_bit(input logic [IDX_W-1:0] sz,
                                  input logic [IDX_W-1:0] ix,
                                  input logic [IDX_W-1:0] iy);
    logic b;
    b = 1'b0;
    if (sz == IDX_W'(SIZE_HARD))
      b = defuse_arr_hard[ix[3:0]][iy[3:0]];
    else if (sz == IDX_W'(SIZE_MEDIUM)) begin
      if (ix < IDX_W'(10) && iy < IDX_W'(10))
        b = defuse_arr_medium[ix[3:0]][iy[3:0]];
    end else
      b = defuse_arr_easy[ix[2:0]][iy[2:0]];
    return b;
  endfunction

`ifdef DEFUSE_SCAN_SKIP_EN
  logic ptr_act_q, ptr_act_d;
  logic adv, pbit;
`endif

  // Scan FSM: next state, record load and flag accumulation.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = valid_q;
    def_d   = def_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
`ifdef DEFUSE_SCAN_SKIP_EN
    ptr_act_d = ptr_act_q;
    adv       = ptr_act_q & (~valid_q | out_ready);
    pbit      = rd_bit(size_q, px, py);
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          size_d  = IDX_W'(level_to_size(level));
          cnt_d   = '0;
          clr     = 1'b1;
          cx_d    = '0;
          cy_d    = '0;
          state_d = ST_SCAN;
`ifdef DEFUSE_SCAN_SKIP_EN
          valid_d   = 1'b0;
          def_d     = 1'b0;
          ptr_act_d = 1'b1;
`else
          valid_d = 1'b1;
          def_d   = rd_bit(size_d, '0, '0);
`endif
        end
      end
      ST_SCAN: begin
`ifdef DEFUSE_SCAN_SKIP_EN
        // Slot drains on accept; the pointer refills it with flagged cells only.
        if (valid_q & out_ready) valid_d = 1'b0;
        if (adv) begin
          cnt_d = cnt_q + CNT_W'(pbit);
          if (pbit) begin
            valid_d = 1'b1;
            cx_d    = px;
            cy_d    = py;
            def_d   = 1'b1;
          end
          if (last) ptr_act_d = 1'b0;
          else      inc       = 1'b1;
        end
        if ((~ptr_act_q | (adv & last)) & ~valid_d) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
`else
        // Counter tracks the record on display; prefetch the next cell's bit.
        if (valid_q & out_ready) begin
          cnt_d = cnt_q + CNT_W'(def_q);
          if (last) begin
            valid_d = 1'b0;
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            inc   = 1'b1;
            cx_d  = pnx;
            cy_d  = pny;
            def_d = rd_bit(size_q, pnx, pny);
          end
        end
`endif
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; synchronous reset aborts any scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      def_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef DEFUSE_SCAN_SKIP_EN
      ptr_act_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      def_q   <= def_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef DEFUSE_SCAN_SKIP_EN
      ptr_act_q <= ptr_act_d;
`endif
    end
  end

  assign cell_valid   = valid_q;
  assign cell_x       = cx_q;
  assign cell_y       = cy_q;
  assign cell_defused = def_q;
  assign busy         = (state_q == ST_SCAN);
  assign done         = done_q;
  assign flag_count   = cnt_q;

endmodule

// File: tb/tb_defuse_scan.sv
// Randomized self-checking bench for defuse_scan: a queue of expected
// records is built from the board contents and row-major order, and the
// DUT stream is matched against it handshake by handshake.
module tb_defuse_scan;

  localparam int IDX_W = 5;
  localparam int CNT_W = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [1:0]         level;
  logic [7:0][7:0]    defuse_arr_easy;
  logic [9:0][9:0]    defuse_arr_medium;
  logic [15:0][15:0]  defuse_arr_hard;
  logic               out_ready;
  logic               cell_valid;
  logic [IDX_W-1:0]   cell_x, cell_y;
  logic               cell_defused;
  logic               busy, done;
  logic [CNT_W-1:0]   flag_count;

  int checks = 0;
  int errors = 0;
  bit board [16][16];

  defuse_scan #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .level             (level),
    .defuse_arr_easy   (defuse_arr_easy),
    .defuse_arr_medium (defuse_arr_medium),
    .defuse_arr_hard   (defuse_arr_hard),
    .out_ready         (out_ready),
    .cell_valid        (cell_valid),
    .cell_x            (cell_x),
    .cell_y            (cell_y),
    .cell_defused      (cell_defused),
    .busy              (busy),
    .done              (done),
    .flag_count        (flag_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clear_board();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) board[x][y] = 1'b0;
  endtask

  task automatic rand_board();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) board[x][y] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic load_board();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        defuse_arr_hard[x][y] = board[x][y];
        if (x < 10 && y < 10) defuse_arr_medium[x][y] = board[x][y];
        if (x < 8 && y < 8)   defuse_arr_easy[x][y]   = board[x][y];
      end
  endtask

  function automatic logic [22:0] all_outs();
    return {cell_valid, busy, done, flag_count, cell_x, cell_y, cell_defused};
  endfunction

  // rmode: 0 ready always high, 1 toggling, 2 random.
  task automatic run_scan(input int lvl, input int rmode, input bit abort_23, input bit mid_start);
    int n, sum, cyc, exp_cnt, lat, budget;
    bit prev_hold, early_done, aborted, ms_done, late_done;
    logic [10:0] q[$];
    n = (lvl == 3) ? 16 : (lvl == 2) ? 10 : 8;
    sum = 0; cyc = 0; exp_cnt = 0;
    prev_hold = 0; early_done = 0; aborted = 0; ms_done = 0;
    budget = n * n * 4 + 20;
    for (int y = 0; y < n; y++)
      for (int x = 0; x < n; x++) begin
        if (board[x][y]) exp_cnt++;
`ifdef DEFUSE_SCAN_SKIP_EN
        if (board[x][y])
`endif
          q.push_back({5'(x), 5'(y), board[x][y]});
      end
    load_board();
    @(negedge clk); level = 2'(lvl); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (q.size() > 0 && cyc < budget && !aborted) begin
      start = 1'b0;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (done) early_done = 1;
      if (prev_hold) chk("hold_vld", cell_valid, 1);
`ifndef DEFUSE_SCAN_SKIP_EN
      chk("vld", cell_valid, 1);
      chk("cnt_run", flag_count, sum);
`endif
      prev_hold = 0;
      if (cell_valid) begin
        chk("rec", {cell_x, cell_y, cell_defused}, q[0]);
        if (abort_23 && cell_x == 5'd2 && cell_y == 5'd3) begin
          rst = 1'b1;
          @(negedge clk);
          chk("abort_zero", all_outs(), 0);
          rst = 1'b0;
          late_done = 0;
          repeat (4) begin
            @(negedge clk);
            if (done || cell_valid) late_done = 1;
          end
          chk("abort_quiet", late_done, 0);
          aborted = 1;
        end else if (out_ready) begin
          sum += int'(q[0][0]);
          void'(q.pop_front());
          if (mid_start && !ms_done && q.size() == n * n - 5) begin
            start = 1'b1;
            level = 2'd3;
            ms_done = 1;
          end
        end else prev_hold = 1;
      end
      if (!aborted) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (aborted) return;
    start = 1'b0;
    chk("timeout", q.size(), 0);
    chk("early_done", early_done, 0);
    lat = 1;
    while (!done && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done, 1);
`ifndef DEFUSE_SCAN_SKIP_EN
    chk("done_lat", lat, 1);
`endif
    chk("fin_vld", cell_valid, 0);
    chk("fin_busy", busy, 0);
    chk("fin_cnt", flag_count, exp_cnt);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("cnt_hold", flag_count, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; level = 2'd0; out_ready = 1'b0;
    clear_board();
    load_board();
    repeat (3) @(negedge clk);
    chk("rst_outs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", all_outs(), 0);

    // Easy, no flags, ready always high.
    clear_board();
    run_scan(1, 0, 0, 0);

    // Medium, two flags.
    clear_board();
    board[3][4] = 1; board[9][9] = 1;
    run_scan(2, 0, 0, 0);

    // Hard, every cell flagged, ready toggling.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) board[x][y] = 1'b1;
    run_scan(3, 1, 0, 0);

    // Reset mid-scan at (2,3), then a clean restart.
    rand_board();
    board[2][3] = 1;
    run_scan(1, 2, 1, 0);
    run_scan(1, 0, 0, 0);

    // start + level change during an easy scan are ignored.
    rand_board();
    run_scan(1, 2, 0, 1);

    // Sparse easy board.
    clear_board();
    board[1][0] = 1; board[5][6] = 1;
    run_scan(1, 2, 0, 0);

    // Random levels (including code 0), boards and back-pressure.
    repeat (4) begin
      rand_board();
      run_scan($urandom_range(0, 3), 2, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
